// File: rtl/block_emitter.sv
// Command-driven keyword emitter: serialises BEGIN/END/WORD/FLUSH as "begin ", "end ", "x "
// one byte per transfer while tracking nesting depth. Define BLOCK_EMITTER_UPPER_EN for uppercase keywords.
module block_emitter #(
    parameter int DEPTH_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    output logic               cmd_ready,
    output logic [7:0]         char_out,
    output logic               char_valid,
    input  logic               char_ready,
    output logic [DEPTH_W-1:0] depth,
    output logic               balanced,
    output logic               err,
    output logic [1:0]         dbg_state
);

    // Handshakes: a command moves on cmd_valid && cmd_ready, a byte moves on
    // char_valid && char_ready; a stalled byte holds char_out/char_valid stable.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EMIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        KW_BEGIN = 2'd0,
        KW_END   = 2'd1,
        KW_WORD  = 2'd2
    } kw_t;

    localparam logic [1:0] CMD_BEGIN = 2'd0;
    localparam logic [1:0] CMD_END   = 2'd1;
    localparam logic [1:0] CMD_WORD  = 2'd2;
    localparam logic [1:0] CMD_FLUSH = 2'd3;

`ifdef BLOCK_EMITTER_UPPER_EN
    localparam logic [7:0] CASE_BIT = 8'h00;
`else
    localparam logic [7:0] CASE_BIT = 8'h20;
`endif

    localparam logic [7:0] CH_B  = 8'h42 | CASE_BIT;
    localparam logic [7:0] CH_E  = 8'h45 | CASE_BIT;
    localparam logic [7:0] CH_G  = 8'h47 | CASE_BIT;
    localparam logic [7:0] CH_I  = 8'h49 | CASE_BIT;
    localparam logic [7:0] CH_N  = 8'h4E | CASE_BIT;
    localparam logic [7:0] CH_D  = 8'h44 | CASE_BIT;
    localparam logic [7:0] CH_X  = 8'h58 | CASE_BIT;
    localparam logic [7:0] CH_SP = 8'h20;

    localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    kw_t                r_kw;
    logic [2:0]         r_idx;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_balanced;
    logic               r_err;

    state_t             w_state_nxt;
    kw_t                w_kw_nxt;
    logic [2:0]         w_idx_nxt;
    logic [DEPTH_W-1:0] w_depth_nxt;
    logic               w_err_nxt;
    logic [2:0]         w_last_idx;

    function automatic logic [7:0] kw_byte(input kw_t kw, input logic [2:0] idx);
        logic [7:0] b;
        b = CH_SP;
        case (kw)
            KW_BEGIN: begin
                case (idx)
                    3'd0:    b = CH_B;
                    3'd1:    b = CH_E;
                    3'd2:    b = CH_G;
                    3'd3:    b = CH_I;
                    3'd4:    b = CH_N;
                    default: b = CH_SP;
                endcase
            end
            KW_END: begin
                case (idx)
                    3'd0:    b = CH_E;
                    3'd1:    b = CH_N;
                    3'd2:    b = CH_D;
                    default: b = CH_SP;
                endcase
            end
            KW_WORD: begin
                b = (idx == 3'd0) ? CH_X : CH_SP;
            end
            default: b = CH_SP;
        endcase
        return b;
    endfunction

    always_comb begin
        case (r_kw)
            KW_BEGIN: w_last_idx = 3'd5;
            KW_END:   w_last_idx = 3'd3;
            default:  w_last_idx = 3'd1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kw_nxt    = r_kw;
        w_idx_nxt   = r_idx;
        w_depth_nxt = r_depth;
        w_err_nxt   = r_err;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_idx_nxt = 3'd0;
                    case (cmd)
                        CMD_BEGIN: begin
                            if (&r_depth) begin
                                w_err_nxt = 1'b1;
                            end else begin
                                w_depth_nxt = r_depth + DEPTH_ONE;
                                w_kw_nxt    = KW_BEGIN;
                                w_state_nxt = S_EMIT;
                            end
                        end
                        CMD_END: begin
                            if (r_depth == '0) begin
                                w_err_nxt = 1'b1;
                            end else begin
                                w_depth_nxt = r_depth - DEPTH_ONE;
                                w_kw_nxt    = KW_END;
                                w_state_nxt = S_EMIT;
                            end
                        end
                        CMD_WORD: begin
                            w_kw_nxt    = KW_WORD;
                            w_state_nxt = S_EMIT;
                        end
                        CMD_FLUSH: begin
                            if (r_depth != '0) begin
                                w_kw_nxt    = KW_END;
                                w_state_nxt = S_FLUSH;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_EMIT: begin
                if (char_ready) begin
                    if (r_idx == w_last_idx) begin
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            S_FLUSH: begin
                // Each completed "end " closes one block; the last one returns to IDLE.
                if (char_ready) begin
                    if (r_idx == 3'd3) begin
                        w_idx_nxt   = 3'd0;
                        w_depth_nxt = r_depth - DEPTH_ONE;
                        if (r_depth == DEPTH_ONE) begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_kw       <= KW_BEGIN;
            r_idx      <= 3'd0;
            r_depth    <= '0;
            r_balanced <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_kw       <= w_kw_nxt;
            r_idx      <= w_idx_nxt;
            r_depth    <= w_depth_nxt;
            r_balanced <= (w_depth_nxt == '0);
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        cmd_ready  = (r_state == S_IDLE);
        char_valid = (r_state != S_IDLE);
        char_out   = char_valid ? kw_byte(r_kw, r_idx) : 8'h00;
        depth      = r_depth;
        balanced   = r_balanced;
        err        = r_err;
        dbg_state  = r_state;
    end

endmodule

// File: doc/block_emitter.md
# block_emitter

Command-driven ASCII keyword generator: the transmit-side counterpart of the block-nesting checker. Accepts BEGIN/END/WORD/FLUSH commands over a valid/ready handshake and serialises them as a space-separated byte stream ("begin ", "end ", "x "), one byte per transfer, while tracking nesting depth. Sits upstream of the checker in test and loopback paths, so the checker's `result` tracks this block's `balanced`.

## Interface
- `DEPTH_W`, 16: width of the nesting-depth counter.
- `clk`  in  1  single clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd`  in  2  0=BEGIN, 1=END, 2=WORD, 3=FLUSH.
- `cmd_ready`  out  1  high only in IDLE; a command is accepted on `cmd_valid && cmd_ready`.
- `char_out`  out  8  ASCII byte.
- `char_valid`  out  1  `char_out` holds a byte.
- `char_ready`  in  1  downstream accepts; a byte transfers on `char_valid && char_ready`.
- `depth`  out  DEPTH_W  current number of open blocks.
- `balanced`  out  1  `depth == 0`.
- `err`  out  1  sticky protocol error; cleared only by reset.

## Operation
- States: IDLE, EMIT, FLUSH. A 3-bit index selects the byte within the current keyword; a keyword-select register chooses the string.
- IDLE: `cmd_ready=1`, `char_valid=0`. On accept:
  - BEGIN: if `depth` is all-ones, set `err`, emit nothing and stay in IDLE. Otherwise `depth+1`, then EMIT "begin " (6 bytes).
  - END: if `depth==0`, set `err`, emit nothing and stay in IDLE. Otherwise `depth-1`, then EMIT "end " (4 bytes).
  - WORD: EMIT "x " (2 bytes); `depth` is unchanged.
  - FLUSH: if `depth==0`, complete with no bytes and stay in IDLE. Otherwise go to FLUSH.
- Depth updates on BEGIN and END take effect at the acceptance edge.
- EMIT:
  - Present byte[index]; advance the index on each transfer.
  - On the final byte's transfer (always 0x20), return to IDLE.
- FLUSH:
  - Emit "end " repeatedly.
  - `depth` decrements on each transfer of the trailing 0x20.
  - When the decrement reaches 0, return to IDLE.
- Stall: while `char_valid && !char_ready`, `char_out` and `char_valid` hold stable and state does not advance.
- `err` never blocks operation. Only rejected commands set it, and it never clears except on reset.
- Arithmetic: `depth` never wraps. Saturation is guarded by the BEGIN/END rejection rules above.

## Timing
- Reset values: `char_out=8'h00`, `char_valid=0`, `cmd_ready=1`, `depth=0`, `balanced=1`, `err=0`, state IDLE.
- Reset mid-keyword or mid-FLUSH: the stream is abandoned. The cycle after reset, `char_valid=0`, `depth=0`, and no partial keyword completes.
- Accept at edge t → first byte valid in the cycle after t.
- With `char_ready` held high, a keyword of N bytes occupies N cycles. `cmd_ready` rises the cycle after the last transfer, so per-command throughput is N+1 cycles.
- Rejected or no-op commands (END at depth 0, BEGIN at max depth, FLUSH at depth 0) keep `cmd_ready=1`; the next command can be accepted on the following edge.
- `balanced` and `depth` are registered and reflect the update one cycle after the causing edge.

## Configuration
- `BLOCK_EMITTER_UPPER_EN`:
  - Defined: keywords are uppercase ("BEGIN ", "END ", "X ").
  - Undefined: keywords are lowercase.
  - Space byte, lengths, timing and depth behaviour are identical either way.

## Test plan
- Reset, then BEGIN with `char_ready=1` → bytes 0x62,0x65,0x67,0x69,0x6E,0x20 on 6 consecutive cycles; `depth=1`, `balanced=0`, `cmd_ready=1` on the 7th cycle.
- BEGIN, BEGIN, FLUSH → "begin begin end end ", `depth` 2→1→0, `balanced=1` after the final 0x20.
- END at `depth=0` → no `char_valid`, `err=1`, `depth=0`; a following WORD still emits 0x78,0x20.
- Stall: during "end ", drop `char_ready` for 3 cycles on byte 'n' → `char_out=0x6E` held stable for all 3 cycles, with no duplicated or dropped bytes.
- Assert reset on byte 3 of "begin " → next cycle `char_valid=0`, `depth=0`, `err=0`, `cmd_ready=1`.
- With `BLOCK_EMITTER_UPPER_EN` defined, BEGIN → 0x42,0x45,0x47,0x49,0x4E,0x20.
